// File: rtl/request_encoder_pkg.sv
// Shared constants, state encoding and popcount helper for the request encoder.
package request_encoder_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] popcount32(input logic [N_REQ-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/request_encoder_if.sv
// Load/stream handshake bundle between a producer/consumer and the request encoder.
interface request_encoder_if;
    import request_encoder_pkg::*;

    logic             load;
    logic [N_REQ-1:0] req_in;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] stream_out;
    logic [N_REQ-1:0] grant;
    logic             last;
    logic             busy;
    logic [CNT_W-1:0] count;

    modport slave (
        input  load, req_in, out_ready,
        output out_valid, stream_out, grant, last, busy, count
    );

    modport master (
        output load, req_in, out_ready,
        input  out_valid, stream_out, grant, last, busy, count
    );

endinterface

// File: rtl/request_encoder_lowest_set32.sv
// Combinational lowest-set-bit finder: one-hot, binary index and found flag.
module lowest_set32 (
    input  logic [31:0] i_vec,
    output logic [31:0] o_onehot,
    output logic [4:0]  o_idx,
    output logic        o_found
);

    assign o_onehot = i_vec & (~i_vec + 32'd1);
    assign o_found  = |i_vec;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (i_vec[i]) o_idx = i[4:0];
        end
    end

endmodule

// File: rtl/request_encoder.sv
// Serves the labels of a captured request vector one per transfer, lowest first.
// state | meaning
// IDLE  | no batch; a non-zero load is captured
// SERVE | batch in progress; lowest pending label presented, load ignored
module request_encoder
    import request_encoder_pkg::*;
#(
    parameter int N_REQ = request_encoder_pkg::N_REQ,
    parameter int IDX_W = request_encoder_pkg::IDX_W
) (
    input  logic               clock,
    input  logic               reset,
    request_encoder_if.slave   bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic [N_REQ-1:0] r_pend;
    logic [CNT_W-1:0] r_count;
    logic [N_REQ-1:0] w_onehot;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic             w_accept;
    logic             w_xfer;
    logic             w_valid;

    lowest_set32 u_lowest (
        .i_vec    (r_pend),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_found  (w_found)
    );

    assign w_valid  = (r_state == SERVE);
    assign w_accept = (r_state == IDLE) && bus.load && (|bus.req_in);
    assign w_xfer   = w_valid && w_found && bus.out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next_state = SERVE;
            SERVE: if (w_xfer && ((r_pend & ~w_onehot) == '0)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_pend  <= bus.req_in;
            r_count <= popcount32(bus.req_in);
        end else if (w_xfer) begin
            r_pend  <= r_pend & ~w_onehot;
            r_count <= r_count - 1'b1;
        end
    end

    // Index is sent MSB-first so it matches the 5-to-32 decoder on the far side.
    assign bus.stream_out = w_valid ? {w_idx[0], w_idx[1], w_idx[2], w_idx[3], w_idx[4]} : '0;
    assign bus.grant      = w_valid ? w_onehot : '0;
    assign bus.out_valid  = w_valid;
    assign bus.busy       = w_valid;
    assign bus.count      = r_count;
    assign bus.last       = w_valid && (r_count == 6'd1);

endmodule

// File: tb/tb_request_encoder.sv
// Scoreboard bench for request_encoder: expected labels queued at load, checked at output.
module tb_request_encoder;

    typedef struct {
        logic [4:0] idx;
        logic [5:0] cnt;
    } exp_t;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t q_stage[$];
    exp_t q_exp[$];

    request_encoder_if bus ();

    request_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] msb_first(input logic [4:0] k);
        return {k[0], k[1], k[2], k[3], k[4]};
    endfunction

    // Loads accepted at an edge become visible one cycle later.
    initial begin
        forever begin
            @(posedge clock);
            while (q_stage.size() != 0) q_exp.push_back(q_stage.pop_front());
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q_exp.size() != 0});
            chk("busy", {31'b0, bus.busy}, {31'b0, q_exp.size() != 0});
            if (bus.out_valid && q_exp.size() != 0) begin
                chk("stream_out", {27'b0, bus.stream_out}, {27'b0, msb_first(q_exp[0].idx)});
                chk("grant", bus.grant, 32'd1 << q_exp[0].idx);
                chk("count", {26'b0, bus.count}, {26'b0, q_exp[0].cnt});
                chk("last", {31'b0, bus.last}, {31'b0, q_exp[0].cnt == 6'd1});
                if (bus.out_ready) void'(q_exp.pop_front());
            end else if (!bus.out_valid) begin
                chk("idle_stream", {27'b0, bus.stream_out}, 32'd0);
                chk("idle_grant", bus.grant, 32'd0);
                chk("idle_last", {31'b0, bus.last}, 32'd0);
            end
        end
    end

    // Called at posedge+1; holds load for one edge.
    task automatic load_req(input logic [31:0] v);
        logic [5:0] c;
        bus.load   = 1'b1;
        bus.req_in = v;
        if (q_exp.size() == 0 && q_stage.size() == 0 && v != 32'd0) begin
            c = 6'd0;
            for (int i = 0; i < 32; i++) c = c + {5'b0, v[i]};
            for (int i = 0; i < 32; i++) begin
                if (v[i]) begin
                    q_stage.push_back('{idx: i[4:0], cnt: c});
                    c = c - 6'd1;
                end
            end
        end
        @(posedge clock); #1;
        bus.load   = 1'b0;
        bus.req_in = 32'd0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && (q_exp.size() != 0 || q_stage.size() != 0); i++) begin
            @(posedge clock); #1;
        end
        chk(tag, q_exp.size() + q_stage.size(), 32'd0);
        cycles(2);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b0;
        bus.load      = 1'b0;
        bus.req_in    = 32'd0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_count", {26'b0, bus.count}, 32'd0);
        chk("rst_grant", bus.grant, 32'd0);
        chk("rst_stream", {27'b0, bus.stream_out}, 32'd0);
        chk("rst_last", {31'b0, bus.last}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        cycles(2);

        bus.out_ready = 1'b1;
        load_req(32'h0000_000A);
        drain("drain_0xA");

        bus.out_ready = 1'b0;
        load_req(32'h8000_0001);
        cycles(3);
        bus.out_ready = 1'b1;
        drain("drain_0x80000001");

        load_req(32'h0000_0000);
        cycles(3);
        chk("zero_load_busy", {31'b0, bus.busy}, 32'd0);

        bus.out_ready = 1'b0;
        load_req(32'h0001_0000);
        load_req(32'h0000_0002);
        cycles(1);
        bus.out_ready = 1'b1;
        drain("drain_busy_load");

        load_req(32'hFFFF_FFFF);
        drain("drain_all_ones");

        load_req(32'h0000_00F0);
        @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        q_exp.delete();
        q_stage.delete();
        #1;
        chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_count", {26'b0, bus.count}, 32'd0);
        chk("midrst_grant", bus.grant, 32'd0);
        chk("midrst_stream", {27'b0, bus.stream_out}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        cycles(5);
        chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
REQUEST_ENCODER -- requirements
Module: request_encoder

Interface
REQ-001 The module SHALL have parameter N_REQ, default 32, meaning request vector width; only 32 is supported.
REQ-002 The module SHALL have parameter IDX_W, default 5, meaning encoded index width.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset.
REQ-004 The module SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low; 0 clears all state.
REQ-006 The module SHALL have port load, input, 1 bit: capture req_in this cycle.
REQ-007 The module SHALL have port req_in, input, 32 bits: one bit per label; bit k means label k is requested.
REQ-008 The module SHALL have port out_ready, input, 1 bit: consumer accepts the current index.
REQ-009 The module SHALL have port out_valid, output, 1 bit: stream_out holds a valid index.
REQ-010 The module SHALL have port stream_out, output, 5 bits: encoded index of the served label.
REQ-011 The module SHALL have port grant, output, 32 bits: one-hot copy of the served label; all zero when out_valid=0.
REQ-012 The module SHALL have port last, output, 1 bit: the served label is the final pending one.
REQ-013 The module SHALL have port busy, output, 1 bit: a batch is in progress and load is ignored.
REQ-014 The module SHALL have port count, output, 6 bits: number of labels still pending, 0..32.

Function
REQ-015 The module SHALL use two states, IDLE and SERVE, and SHALL hold the pending vector pend[31:0] in a register.
REQ-016 In IDLE, load=1 with req_in!=0 SHALL set pend=req_in and move to SERVE on the same edge.
REQ-017 In IDLE, load=1 with req_in==0 SHALL be ignored, leaving the module in IDLE with pend=0.
REQ-018 In SERVE, load SHALL be ignored.
REQ-019 busy SHALL be 1 exactly when the state is SERVE.
REQ-020 Latency SHALL be one cycle: a load accepted at edge t gives out_valid=1 in the cycle after t.
REQ-021 out_valid SHALL equal (state==SERVE).
REQ-022 The served label k SHALL be the lowest-numbered set bit of pend; label 0 has the highest priority.
REQ-023 stream_out SHALL encode k MSB-first: stream_out[0]=k[4], stream_out[1]=k[3], stream_out[2]=k[2], stream_out[3]=k[1], stream_out[4]=k[0]. This makes it the exact inverse of the team's 5-to-32 decoder.
REQ-024 When out_valid=0, stream_out SHALL be 0.
REQ-025 A transfer SHALL occur when out_valid=1 and out_ready=1; on that edge bit k of pend SHALL be cleared.
REQ-026 If the transfer clears the final set bit, the state SHALL move to IDLE on that same edge; otherwise it SHALL stay in SERVE, and the next index SHALL appear in the following cycle with no bubble.
REQ-027 With out_ready=0, stream_out, grant, last and count SHALL hold stable.
REQ-028 count SHALL equal popcount(pend) and SHALL decrement by 1 on each transfer.
REQ-029 last SHALL equal out_valid AND (count==1).
REQ-030 All outputs SHALL be functions of registered state only; there SHALL be no combinational path from req_in or out_ready to any output.

Reset
REQ-031 Asserting reset (reset=0) SHALL immediately force state=IDLE and pend=0, regardless of clock.
REQ-032 Under reset, out_valid=0, stream_out=0, grant=0, last=0, busy=0 and count=0.
REQ-033 Reset asserted in the middle of a batch SHALL discard all pending labels; no index SHALL be emitted after release until a new load.

Structure
REQ-034 A shared package SHALL hold N_REQ, IDX_W and the state encoding (IDLE=0, SERVE=1).
REQ-035 The lowest-set-bit search SHALL be a separate combinational sub-module, lowest_set32. It takes pend[31:0] and returns the one-hot vector, the 5-bit index k, and a found flag.
REQ-036 The MSB-first bit reordering SHALL be done in request_encoder, not in lowest_set32.

Verification
REQ-037 Scenario: load req_in=0x0000000A, out_ready=1 -> next cycle stream_out=5'b10000 (k=1), count=2, last=0; following cycle stream_out=5'b11000 (k=3), last=1; then busy=0, out_valid=0.
REQ-038 Scenario: load 0x80000001 with out_ready=0 for 3 cycles -> stream_out=5'b00000, grant=0x00000001, count=2 held for all 3 cycles; raising out_ready gives k=31, stream_out=5'b11111.
REQ-039 Scenario: load 0x00000000 -> busy stays 0 and out_valid stays 0.
REQ-040 Scenario: load 0x00010000, then load=1 with req_in=0x00000002 while busy -> exactly one index is emitted, k=16, stream_out=5'b00001; 0x2 is ignored.
REQ-041 Scenario: load 0xFFFFFFFF, out_ready=1 -> 32 consecutive transfers k=0..31 with no gaps; last=1 only on k=31; count goes 32 down to 1.
REQ-042 Scenario: reset=0 asserted mid-edge during a 0x000000F0 batch after one transfer -> outputs zero immediately; after release out_valid stays 0.
